// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame shape and a parity helper.
// Imported by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_PARITY_EN  = 0;
  localparam int UART_PARITY_ODD = 0;
  localparam int UART_STOP_BITS  = 1;

  // XOR of the low nbits of data, inverted for odd parity.
  function automatic logic parity_of(input logic [7:0] data, input int nbits, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts one byte in IDLE and serialises start/data/parity/stop bits,
// advancing one bit per external baud tick. txd comes straight from a flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int PARITY_EN  = UART_PARITY_EN,
  parameter int PARITY_ODD = UART_PARITY_ODD,
  parameter int STOP_BITS  = UART_STOP_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        parity_q, parity_d;
  logic        txd_q, txd_d;
  logic        done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    txd_d      = txd_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        // Ticks are not looked at here, so a tick on the accept edge is dropped.
        if (tx_valid) begin
          shift_d    = tx_data;
          parity_d   = parity_of(tx_data, DATA_BITS, PARITY_ODD != 0);
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = ARM;
        end
      end
      ARM: begin
        if (tick) begin
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
            if (PARITY_EN != 0) begin
              txd_d   = parity_q;
              state_d = PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = STOP;
            end
          end else begin
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign txd      = txd_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameterisations share clk/rst/tick, one is driven at a time.
// Ticks arrive every 12 clks; line bits are expected to hold for exactly 12 clks each.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] tx_valid_v = 4'b0000;
  logic [3:0] tx_ready_v, txd_v, tx_busy_v, tx_done_v;

  int checks = 0;
  int errors = 0;
  int tick_phase = 0;
  int done_cnt [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_phase <= (tick_phase == 11) ? 0 : tick_phase + 1;
    tick       <= (tick_phase == 11);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) done_cnt[i] <= done_cnt[i] + int'(tx_done_v[i]);
  end

  // 0: defaults, 1: even parity, 2: odd parity, 3: 5 data bits + 2 stop bits
  uart_tx u_def (.clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data), .tx_valid(tx_valid_v[0]),
                 .tx_ready(tx_ready_v[0]), .txd(txd_v[0]), .tx_busy(tx_busy_v[0]), .tx_done(tx_done_v[0]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_pe (.clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data),
                 .tx_valid(tx_valid_v[1]), .tx_ready(tx_ready_v[1]), .txd(txd_v[1]), .tx_busy(tx_busy_v[1]),
                 .tx_done(tx_done_v[1]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_po (.clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data),
                 .tx_valid(tx_valid_v[2]), .tx_ready(tx_ready_v[2]), .txd(txd_v[2]), .tx_busy(tx_busy_v[2]),
                 .tx_done(tx_done_v[2]));
  uart_tx #(.DATA_BITS(5), .STOP_BITS(2)) u_52 (.clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data),
                 .tx_valid(tx_valid_v[3]), .tx_ready(tx_ready_v[3]), .txd(txd_v[3]), .tx_busy(tx_busy_v[3]),
                 .tx_done(tx_done_v[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the selected DUT idle; accepted on the next posedge.
  task automatic send(input int sel, input logic [7:0] data, input string tag);
    tx_data = data;
    tx_valid_v[sel] = 1'b1;
    @(negedge clk);
    tx_valid_v[sel] = 1'b0;
    chk($sformatf("%s accept_ready", tag), 32'(tx_ready_v[sel]), 32'd0);
    chk($sformatf("%s accept_busy", tag), 32'(tx_busy_v[sel]), 32'd1);
    chk($sformatf("%s arm_txd", tag), 32'(txd_v[sel]), 32'd1);
  endtask

  // bits[0] is the start bit; every bit must hold for 12 clks, then tx_done must pulse.
  task automatic expect_frame(input int sel, input int nbits, input logic [15:0] bits, input string tag);
    int waitc;
    bit ok;
    waitc = 0;
    while (txd_v[sel] !== 1'b0 && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    chk($sformatf("%s start_seen", tag), 32'(txd_v[sel]), 32'd0);
    for (int i = 0; i < nbits; i++) begin
      ok = 1'b1;
      for (int k = 0; k < 12; k++) begin
        if (i != 0 || k != 0) @(negedge clk);
        if (txd_v[sel] !== bits[i]) ok = 1'b0;
      end
      chk($sformatf("%s bit%0d(exp %0b)", tag, i, bits[i]), 32'(ok), 32'd1);
    end
    @(negedge clk);
    chk($sformatf("%s done_pulse", tag), 32'(tx_done_v[sel]), 32'd1);
    chk($sformatf("%s done_busy", tag), 32'(tx_busy_v[sel]), 32'd0);
    chk($sformatf("%s done_ready", tag), 32'(tx_ready_v[sel]), 32'd1);
  endtask

  initial begin
    int snap;
    int waitc;
    bit ok;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst txd", 32'(txd_v), 32'hF);
    chk("rst ready", 32'(tx_ready_v), 32'hF);
    chk("rst busy", 32'(tx_busy_v), 32'h0);
    chk("rst done", 32'(tx_done_v), 32'h0);

    // 0xA5 accepted on the first edge after reset release
    tx_data = 8'hA5;
    tx_valid_v[0] = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    tx_valid_v[0] = 1'b0;
    chk("a5 accept_ready", 32'(tx_ready_v[0]), 32'd0);
    chk("a5 accept_busy", 32'(tx_busy_v[0]), 32'd1);
    snap = done_cnt[0];
    expect_frame(0, 10, 16'b11_0100_1010, "a5");
    repeat (5) @(negedge clk);
    chk("a5 one_done", 32'(done_cnt[0] - snap), 32'd1);

    // Parity: 0x07 -> even parity bit 1, odd parity bit 0
    send(1, 8'h07, "pe07");
    expect_frame(1, 11, 16'b110_0000_1110, "pe07");
    send(2, 8'h07, "po07");
    expect_frame(2, 11, 16'b100_0000_1110, "po07");

    // 5 data bits, 2 stop bits: 8 tick periods total
    snap = done_cnt[3];
    send(3, 8'h1F, "s2_1f");
    expect_frame(3, 8, 16'b1111_1110, "s2_1f");
    repeat (5) @(negedge clk);
    chk("s2_1f one_done", 32'(done_cnt[3] - snap), 32'd1);

    // Back-to-back with tx_valid held; tx_data changes mid-frame
    tx_data = 8'h55;
    tx_valid_v[0] = 1'b1;
    @(negedge clk);
    chk("b2b accept1", 32'(tx_ready_v[0]), 32'd0);
    tx_data = 8'hAA;
    expect_frame(0, 10, 16'b10_1010_1010, "b2b55");
    @(negedge clk);
    tx_valid_v[0] = 1'b0;
    chk("b2b ready_1clk", 32'(tx_ready_v[0]), 32'd0);
    expect_frame(0, 10, 16'b11_0101_0100, "b2bAA");

    // Tick coincident with accept edge is ignored
    waitc = 0;
    do begin
      @(negedge clk);
      #1;
      waitc++;
    end while (tick !== 1'b1 && waitc < 30);
    chk("coinc tick_found", 32'(tick), 32'd1);
    tx_data = 8'h3C;
    tx_valid_v[0] = 1'b1;
    @(negedge clk);
    tx_valid_v[0] = 1'b0;
    chk("coinc accept", 32'(tx_ready_v[0]), 32'd0);
    ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k != 0) @(negedge clk);
      if (txd_v[0] !== 1'b1) ok = 1'b0;
    end
    chk("coinc idle_12clk", 32'(ok), 32'd1);
    @(negedge clk);
    chk("coinc start_at_next_tick", 32'(txd_v[0]), 32'd0);
    waitc = 0;
    while (tx_done_v[0] !== 1'b1 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    chk("coinc done", 32'(tx_done_v[0]), 32'd1);
    @(negedge clk);

    // Reset during data bit 3 of 0x06 (bit3 = 0)
    tx_data = 8'h06;
    tx_valid_v[0] = 1'b1;
    @(negedge clk);
    tx_valid_v[0] = 1'b0;
    waitc = 0;
    while (txd_v[0] !== 1'b0 && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    repeat (54) @(negedge clk);
    chk("rstmid d3_low", 32'(txd_v[0]), 32'd0);
    snap = done_cnt[0];
    #1 rst = 1'b1;
    #1;
    chk("rstmid txd", 32'(txd_v[0]), 32'd1);
    chk("rstmid busy", 32'(tx_busy_v[0]), 32'd0);
    chk("rstmid ready", 32'(tx_ready_v[0]), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("rstmid no_done", 32'(done_cnt[0] - snap), 32'd0);
    send(0, 8'h81, "after_rst81");
    expect_frame(0, 10, 16'b11_0000_0010, "after_rst81");

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
